// File: rtl/bt656cap_dma_if.sv
// FML write-burst bus between the capture DMA scheduler (master) and the memory
// controller (slave).
interface bt656cap_dma_if #(
  parameter int fml_depth = 27
);
  logic [fml_depth-1:0] fml_adr;
  logic                 fml_stb;
  logic                 fml_we;
  logic [7:0]           fml_sel;
  logic [63:0]          fml_do;
  logic                 fml_ack;

  modport master (
    output fml_adr, fml_stb, fml_we, fml_sel, fml_do,
    input  fml_ack
  );

  modport slave (
    input  fml_adr, fml_stb, fml_we, fml_sel, fml_do,
    output fml_ack
  );
endinterface

// File: rtl/bt656cap_dma.sv
// BT.656 capture write-side DMA: packs RGB565 pixels into 4-beat FML bursts via a
// ping-pong buffer and sequences frame start, burst addressing and frame end.
module bt656cap_dma #(
  parameter int fml_depth = 27
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 v_stb,
  input  logic                 v_sof,
  input  logic [15:0]          v_pixel,
  input  logic [fml_depth-6:0] fml_adr_base,
  input  logic                 last_burst,
  output logic                 start_of_frame,
  output logic                 next_burst,
  output logic                 in_frame,
  output logic                 overflow,
  bt656cap_dma_if.master       fml
);
  // state  | meaning
  // IDLE   | wait for a full drain bank; frame end is taken here
  // REQ    | fml_stb high, address held until fml_ack
  // DAT0-3 | beat k of the drain bank on fml_do
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_DAT0, S_DAT1, S_DAT2, S_DAT3
  } state_t;

  state_t               state_q, state_d;
  logic                 fill_bank_q, fill_bank_d;
  logic [3:0]           fill_idx_q, fill_idx_d;
  logic [1:0]           full_q, full_d;
  logic                 drain_bank_q, drain_bank_d;
  logic [14:0]          offset_q, offset_d;
  logic                 overflow_q, overflow_d;
  logic                 in_frame_q, in_frame_d;
  logic                 sof_q, sof_d;
  logic                 next_burst_q, next_burst_d;
  logic                 abort_q, abort_d;
  logic [fml_depth-1:0] adr_q, adr_d;
  logic                 stb_q, stb_d;
  logic [63:0]          do_q, do_d;
  logic [63:0]          buf_q [0:7];
  logic [63:0]          buf_d [0:7];

  logic                 sof_in, busy, burst_done, burst_go;
  logic [fml_depth-6:0] adr_sum;
  logic [2:0]           wr_sel;
  logic [5:0]           lane_lsb;

  assign sof_in     = v_stb & v_sof;
  assign busy       = (state_q != S_IDLE);
  assign burst_done = (state_q == S_DAT3);
  assign adr_sum    = fml_adr_base + {{(fml_depth-20){1'b0}}, offset_q};
  // next_burst_q gives the control side one cycle to raise last_burst
  assign burst_go   = (state_q == S_IDLE) && full_q[drain_bank_q] && in_frame_q &&
                      !last_burst && !next_burst_q && !sof_in;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (burst_go) state_d = S_REQ;
      S_REQ:   if (fml.fml_ack) state_d = S_DAT0;
      S_DAT0:  state_d = S_DAT1;
      S_DAT1:  state_d = S_DAT2;
      S_DAT2:  state_d = S_DAT3;
      S_DAT3:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stb_d = (state_d == S_REQ);
    unique case (state_d)
      S_DAT0:  do_d = buf_q[{drain_bank_q, 2'd0}];
      S_DAT1:  do_d = buf_q[{drain_bank_q, 2'd1}];
      S_DAT2:  do_d = buf_q[{drain_bank_q, 2'd2}];
      S_DAT3:  do_d = buf_q[{drain_bank_q, 2'd3}];
      default: do_d = '0;
    endcase
  end

  always_comb begin
    fill_bank_d  = fill_bank_q;
    fill_idx_d   = fill_idx_q;
    full_d       = full_q;
    drain_bank_d = drain_bank_q;
    offset_d     = offset_q;
    overflow_d   = overflow_q;
    in_frame_d   = in_frame_q;
    sof_d        = 1'b0;
    next_burst_d = 1'b0;
    abort_d      = abort_q;
    adr_d        = adr_q;
    buf_d        = buf_q;
    wr_sel       = '0;
    lane_lsb     = '0;

    // sof_q masks a last_burst still left over from the previous frame
    if (state_q == S_IDLE && last_burst && !sof_q) begin
      in_frame_d = 1'b0;
      full_d     = 2'b00;
    end

    if (burst_done) begin
      full_d[drain_bank_q] = 1'b0;
      drain_bank_d         = ~drain_bank_q;
      abort_d              = 1'b0;
      if (!abort_q && !sof_in) begin
        offset_d     = offset_q + 15'd1;
        next_burst_d = 1'b1;
      end
    end

    // a burst already on the bus keeps its bank; the new frame fills the other one
    if (sof_in) begin
      full_d = 2'b00;
      if (busy && !burst_done) full_d[drain_bank_q] = 1'b1;
      abort_d     = busy && !burst_done;
      fill_bank_d = busy ? ~drain_bank_q : drain_bank_q;
      fill_idx_d  = '0;
      offset_d    = '0;
      overflow_d  = 1'b0;
      in_frame_d  = 1'b1;
      sof_d       = 1'b1;
    end

    if (v_stb && (in_frame_q || sof_in)) begin
      if (full_d[fill_bank_d]) begin
        overflow_d = 1'b1;
      end else begin
        wr_sel   = {fill_bank_d, fill_idx_d[3:2]};
        lane_lsb = {~fill_idx_d[1:0], 4'b0000};
        buf_d[wr_sel][lane_lsb +: 16] = v_pixel;
        if (fill_idx_d == 4'd15) begin
          full_d[fill_bank_d] = 1'b1;
          fill_bank_d         = ~fill_bank_d;
        end
        fill_idx_d = fill_idx_d + 4'd1;
      end
    end

    if (burst_go) adr_d = {adr_sum, 5'b00000};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      fill_bank_q  <= 1'b0;
      fill_idx_q   <= '0;
      full_q       <= '0;
      drain_bank_q <= 1'b0;
      offset_q     <= '0;
      overflow_q   <= 1'b0;
      in_frame_q   <= 1'b0;
      sof_q        <= 1'b0;
      next_burst_q <= 1'b0;
      abort_q      <= 1'b0;
      adr_q        <= '0;
      stb_q        <= 1'b0;
      do_q         <= '0;
    end else begin
      fill_bank_q  <= fill_bank_d;
      fill_idx_q   <= fill_idx_d;
      full_q       <= full_d;
      drain_bank_q <= drain_bank_d;
      offset_q     <= offset_d;
      overflow_q   <= overflow_d;
      in_frame_q   <= in_frame_d;
      sof_q        <= sof_d;
      next_burst_q <= next_burst_d;
      abort_q      <= abort_d;
      adr_q        <= adr_d;
      stb_q        <= stb_d;
      do_q         <= do_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    buf_q <= buf_d;
  end

  assign start_of_frame = sof_q;
  assign next_burst     = next_burst_q;
  assign in_frame       = in_frame_q;
  assign overflow       = overflow_q;
  assign fml.fml_adr    = adr_q;
  assign fml.fml_stb    = stb_q;
  assign fml.fml_we     = 1'b1;
  assign fml.fml_sel    = 8'hff;
  assign fml.fml_do     = do_q;
endmodule

// File: doc/bt656cap_dma.md
# bt656cap_dma

Write-side DMA scheduler for the BT.656 capture path. Packs decoded RGB565 pixels into 32-byte FML write bursts through a ping-pong buffer and sequences frame start, burst addressing and frame end. It takes `fml_adr_base` and `last_burst` from the capture control interface and returns `start_of_frame`, `next_burst` and `in_frame` to it.

## Interface
- `fml_depth`, 27, FML byte-address width.

- `sys_clk` in 1: system clock; all logic on its rising edge.
- `sys_rst` in 1: synchronous, active-low reset.
- `v_stb` in 1: pixel valid, one pixel per cycle max; no backpressure.
- `v_sof` in 1: qualified by `v_stb`; the pixel is the first of a frame.
- `v_pixel` in 16: RGB565 pixel.
- `fml_adr_base` in fml_depth-5: frame buffer base, 32-byte units.
- `last_burst` in 1: from control interface; high means the frame's burst quota is reached.
- `start_of_frame` out 1: one-cycle pulse per accepted `v_sof`.
- `next_burst` out 1: one-cycle pulse per completed, counted burst.
- `in_frame` out 1: capture active.
- `overflow` out 1: sticky; a pixel was dropped in the current frame.
- `fml_adr` out fml_depth: burst byte address, low 5 bits always 0.
- `fml_stb` out 1: burst request.
- `fml_we` out 1: constant 1.
- `fml_sel` out 8: constant 8'hff.
- `fml_do` out 64: write data.
- `fml_ack` in 1: request accepted.

## Operation
- **Buffer.** Two banks of 4×64 bits (16 pixels). Each bank has a full flag.
  - Fill pointer: bank bit plus 4-bit pixel index.
  - Pixel k of a word lands in bits [63-16k:48-16k], so the first pixel is in the MSBs.
- **Pixel accept.** A pixel is written when `v_stb` and `in_frame` are high and the fill bank is not full.
  - If the fill bank is full, the pixel is dropped and `overflow` is set.
  - On index 15: set the bank's full flag, toggle the bank bit, clear the index.
- **`v_sof`** (with `v_stb`), processed before the pixel write in the same cycle:
  - clear both full flags, except the bank currently being drained by the FSM;
  - index ← 0; fill bank ← the bank not being drained (either bank if idle);
  - burst offset ← 0; `overflow` ← 0; `in_frame` ← 1; pulse `start_of_frame`;
  - the `v_sof` pixel is then stored as pixel 0.
- **Burst address.** `fml_adr = {fml_adr_base + offset, 5'b0}`. The sum is `fml_depth-5` bits, wrapping modulo 2^(fml_depth-5). `offset` is 15 bits and increments per counted burst.
- **FSM states:** IDLE, REQ, DAT0, DAT1, DAT2, DAT3.
  - IDLE → REQ when the drain bank is full, `in_frame`=1, `last_burst`=0 and `next_burst`=0. The `next_burst` term gives one guard cycle so the control interface can update `last_burst`. The address is latched on this transition.
  - REQ: `fml_stb`=1 and `fml_adr` stable; on `fml_ack` go to DAT0.
  - DATk: `fml_do` = word k of the drain bank; DAT3 → IDLE.
  - On the DAT3 → IDLE transition: clear the drain bank full flag, toggle the drain bank, offset+1, and pulse `next_burst` in the first IDLE cycle.
- **`v_sof` while the FSM is in REQ/DAT\*.** The burst completes on the bus; `next_burst` and the offset increment are suppressed, and the bank is freed. The drain bank then becomes the first bank filled by the new frame.
- **Frame end.** In IDLE with `last_burst`=1: `in_frame` ← 0, both full flags are cleared, and pixels are ignored until the next `v_sof`.
- **Reset** (mid-burst included): FSM → IDLE immediately, `fml_stb` drops with no bus completion, and all flags and pointers clear.
  - Reset values: `fml_stb` 0, `fml_adr` 0, `fml_do` 0, `start_of_frame` 0, `next_burst` 0, `in_frame` 0, `overflow` 0.
  - `fml_we`=1, `fml_sel`=8'hff.

## Timing
- All outputs are registered.
- `start_of_frame` is high in the cycle after the `v_sof` pixel.
- Bank full at cycle T (16th pixel written at edge T) → `fml_stb` high at T+1 at the earliest.
- `fml_ack` at cycle A → beats on A+1..A+4, with `fml_stb` low from A+1.
- `next_burst` is high at A+5. The earliest next `fml_stb` is A+7, because of the guard cycle.
- Minimum burst period is 7 cycles versus 16 pixel cycles, so a single ping-pong bank absorbs up to 9 cycles of extra `fml_ack` latency per burst without overflow.
- `fml_adr` and `fml_stb` hold from REQ entry until `fml_ack`, regardless of wait length.

## Test plan
- **Reset values.** Drive `sys_rst`=0 for 2 cycles with `v_stb` toggling → all outputs at reset values, no `fml_stb`.
- **Single frame.** `fml_adr_base`=22'h1000; control model sets `last_burst` after 2 bursts; 40 pixels (0x0000..0x0027) with `v_sof` on the first; `fml_ack` 0-wait.
  - Two bursts at 0x20000 and 0x20020.
  - First beat 64'h0000_0001_0002_0003.
  - `next_burst` pulses twice; `in_frame` falls; pixels 32..39 are never written.
- **Ack latency.** `fml_ack` delayed 8 cycles → no overflow; `fml_adr` stable throughout REQ. Delayed 30 cycles → `overflow`=1 and the dropped pixels are absent from memory.
- **SOF mid-burst.** `v_sof` arrives during DAT1 → burst finishes with 4 beats, no `next_burst`. The next burst goes to base offset 0 and carries the new frame's pixel 0 in the MSBs.
- **Address wrap.** `fml_depth`=27, base 22'h3FFFFF → second burst address 0x0000000.
- **Reset mid-burst.** `sys_rst` low in DAT2 → `fml_stb`=0 and FSM in IDLE next cycle; after release, no burst until 16 new pixels after a `v_sof`.
